// File: rtl/demux_stream_router_if.sv
// Stream bundle between one producer, the router and N_OUT consumers.
// The router takes the slave side; the environment drives the master side.
interface demux_stream_router_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
);
  localparam int SEL_W = $clog2(N_OUT);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_bcast;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [7:0]             err_count;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_count
  );
endinterface

// File: rtl/demux_stream_router.sv
// Registered 1-to-N_OUT stream demultiplexer with one FIFO per channel,
// optional broadcast, and a saturating counter of words sent to a nonexistent channel.
module demux_stream_router #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  demux_stream_router_if.slave bus
);
  localparam int SEL_W = $clog2(N_OUT);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SEL_W:0]   N_OUT_L  = (SEL_W + 1)'(N_OUT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [N_OUT-1:0]       full;
  logic [N_OUT-1:0]       valid;
  logic [N_OUT-1:0]       target;
  logic [N_OUT-1:0]       push;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic                   sel_ok;
  logic                   accept;
  logic                   drop;
  logic [7:0]             err_count_q;
  logic [7:0]             err_count_d;

  assign sel_ok = ({1'b0, bus.in_sel} < N_OUT_L);
  // Ready only looks at registered full flags of the targeted channels, so
  // out_ready never reaches in_ready; an out-of-range word targets nothing.
  assign bus.in_ready = ~|(target & full);
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = target & {N_OUT{accept}};
  assign drop         = accept & ~bus.in_bcast & ~sel_ok;

  genvar gi;
  for (gi = 0; gi < N_OUT; gi++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;

    assign target[gi] = bus.in_bcast | (sel_ok & (bus.in_sel == SEL_W'(gi)));
    assign full[gi]   = (cnt_q == FULL_CNT);
    assign valid[gi]  = (cnt_q != '0);
    assign pop        = valid[gi] & bus.out_ready[gi];
    assign out_data[gi*WIDTH +: WIDTH] = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[gi]) begin
          mem_q[wr_ptr_q] <= bus.in_data;
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (push[gi] && !pop) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end else if (!push[gi] && pop) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (drop && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = out_data;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_demux_stream_router.sv
// Directed bench: a 4-channel/depth-2 router and a 3-channel/depth-4 router
// driven from one clock, every expected value hand-computed.
module tb_demux_stream_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   bad;

  always #5 clk = ~clk;

  demux_stream_router_if #(.WIDTH(8), .N_OUT(4)) bus4 ();
  demux_stream_router_if #(.WIDTH(8), .N_OUT(3)) bus3 ();

  demux_stream_router #(.WIDTH(8), .N_OUT(4), .DEPTH(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  demux_stream_router #(.WIDTH(8), .N_OUT(3), .DEPTH(4)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end else begin
      $display("  ok   %s = %h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_sel = '0; bus4.in_bcast = 1'b0;
    bus4.out_ready = 4'hF;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.in_sel = '0; bus3.in_bcast = 1'b0;
    bus3.out_ready = 3'h7;

    // Reset state
    tick(); tick();
    chk("rst_valid", {28'd0, bus4.out_valid}, 32'h0);
    chk("rst_data", bus4.out_data, 32'h0);
    chk("rst_err", {24'd0, bus4.err_count}, 32'h0);
    chk("rst_ready", {31'd0, bus4.in_ready}, 32'h1);
    rst = 1'b0;
    tick();

    // Routing 0xA0..0xA3 to channels 0..3
    for (int k = 0; k < 4; k++) begin
      bus4.in_valid = 1'b1; bus4.in_data = 8'hA0 + 8'(k); bus4.in_sel = 2'(k);
      chk($sformatf("route_rdy%0d", k), {31'd0, bus4.in_ready}, 32'h1);
      tick();
      chk($sformatf("route_vld%0d", k), {28'd0, bus4.out_valid}, 32'(1 << k));
      chk($sformatf("route_dat%0d", k), {24'd0, bus4.out_data[k*8 +: 8]}, 32'hA0 + 32'(k));
    end
    bus4.in_valid = 1'b0;
    tick();
    chk("route_idle", {28'd0, bus4.out_valid}, 32'h0);

    // Backpressure on channel 2
    bus4.out_ready = 4'b1011;
    bus4.in_valid = 1'b1; bus4.in_sel = 2'd2; bus4.in_data = 8'hB0;
    chk("bp_rdy0", {31'd0, bus4.in_ready}, 32'h1);
    tick();
    bus4.in_data = 8'hB1;
    chk("bp_rdy1", {31'd0, bus4.in_ready}, 32'h1);
    tick();
    bus4.in_data = 8'hB2;
    chk("bp_rdy2_full", {31'd0, bus4.in_ready}, 32'h0);
    tick();
    chk("bp_head_b0", {24'd0, bus4.out_data[16 +: 8]}, 32'hB0);
    bus4.out_ready = 4'hF;
    chk("bp_no_comb_path", {31'd0, bus4.in_ready}, 32'h0);
    tick();
    chk("bp_head_b1", {24'd0, bus4.out_data[16 +: 8]}, 32'hB1);
    chk("bp_rdy_after_pop", {31'd0, bus4.in_ready}, 32'h1);
    tick();
    bus4.in_valid = 1'b0;
    chk("bp_head_b2", {24'd0, bus4.out_data[16 +: 8]}, 32'hB2);
    chk("bp_vld_b2", {28'd0, bus4.out_valid}, 32'h4);
    tick();
    chk("bp_drained", {28'd0, bus4.out_valid}, 32'h0);

    // Broadcast blocked by a full channel 1
    bus4.out_ready = 4'b1101;
    bus4.in_valid = 1'b1; bus4.in_sel = 2'd1; bus4.in_data = 8'hC0;
    tick();
    bus4.in_data = 8'hC1;
    tick();
    bus4.in_bcast = 1'b1; bus4.in_sel = 2'd0; bus4.in_data = 8'h5A;
    chk("bc_blocked", {31'd0, bus4.in_ready}, 32'h0);
    tick();
    chk("bc_none_written", {28'd0, bus4.out_valid}, 32'h2);
    chk("bc_ch1_head", {24'd0, bus4.out_data[8 +: 8]}, 32'hC0);
    bus4.out_ready = 4'hF;
    chk("bc_still_blocked", {31'd0, bus4.in_ready}, 32'h0);
    tick();
    chk("bc_ready", {31'd0, bus4.in_ready}, 32'h1);
    chk("bc_ch1_c1", {24'd0, bus4.out_data[8 +: 8]}, 32'hC1);
    tick();
    bus4.in_valid = 1'b0; bus4.in_bcast = 1'b0;
    chk("bc_all_vld", {28'd0, bus4.out_valid}, 32'hF);
    chk("bc_all_data", bus4.out_data, 32'h5A5A5A5A);
    tick();
    chk("bc_drained", {28'd0, bus4.out_valid}, 32'h0);

    // Push and pop on channel 0 at count 1, DEPTH=2 and DEPTH=4
    bus4.in_valid = 1'b1; bus4.in_sel = 2'd0; bus4.in_data = 8'hD0;
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd0; bus3.in_data = 8'hE0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      bus4.in_data = 8'hD0 + 8'(i);
      bus3.in_data = 8'hE0 + 8'(i);
      chk($sformatf("pp2_out%0d", i), {20'd0, bus4.in_ready, bus4.out_valid[0], 2'd0, bus4.out_data[7:0]},
          {20'd0, 1'b1, 1'b1, 2'd0, 8'hD0 + 8'(i - 1)});
      chk($sformatf("pp4_out%0d", i), {20'd0, bus3.in_ready, bus3.out_valid[0], 2'd0, bus3.out_data[7:0]},
          {20'd0, 1'b1, 1'b1, 2'd0, 8'hE0 + 8'(i - 1)});
      tick();
    end
    bus4.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    chk("pp2_last", {24'd0, bus4.out_data[7:0]}, 32'hD8);
    chk("pp4_last", {24'd0, bus3.out_data[7:0]}, 32'hE8);
    tick();
    chk("pp2_count1", {28'd0, bus4.out_valid}, 32'h0);
    chk("pp4_count1", {29'd0, bus3.out_valid}, 32'h0);

    // Out-of-range select on the 3-channel router
    bad = 0;
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_bcast = 1'b0; bus3.in_data = 8'h77;
    for (int i = 1; i <= 300; i++) begin
      if (bus3.in_ready !== 1'b1) bad++;
      tick();
      if (bus3.out_valid !== 3'b000) bad++;
      if (i == 10) chk("oor_err10", {24'd0, bus3.err_count}, 32'd10);
      if (i == 255) chk("oor_err255", {24'd0, bus3.err_count}, 32'd255);
    end
    bus3.in_valid = 1'b0;
    chk("oor_ready_novalid", 32'(bad), 32'd0);
    chk("oor_err_sat", {24'd0, bus3.err_count}, 32'd255);

    // Reset in the middle of a cycle with every channel holding data
    bus4.out_ready = 4'h0; bus3.out_ready = 3'h0;
    bus4.in_valid = 1'b1; bus4.in_bcast = 1'b1; bus4.in_data = 8'hE1;
    bus3.in_valid = 1'b1; bus3.in_bcast = 1'b1; bus3.in_data = 8'hE3;
    tick();
    bus4.in_valid = 1'b0; bus4.in_bcast = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_bcast = 1'b0;
    chk("mr_pre_vld4", {28'd0, bus4.out_valid}, 32'hF);
    chk("mr_pre_vld3", {29'd0, bus3.out_valid}, 32'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_vld4", {28'd0, bus4.out_valid}, 32'h0);
    chk("mr_vld3", {29'd0, bus3.out_valid}, 32'h0);
    chk("mr_data4", bus4.out_data, 32'h0);
    chk("mr_err3", {24'd0, bus3.err_count}, 32'h0);
    tick();
    rst = 1'b0;
    bus4.out_ready = 4'hF; bus3.out_ready = 3'h7;
    bus4.in_valid = 1'b1; bus4.in_sel = 2'd3; bus4.in_data = 8'hF7;
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd2; bus3.in_data = 8'h3C;
    tick();
    bus4.in_valid = 1'b0; bus3.in_valid = 1'b0;
    chk("post_vld4", {28'd0, bus4.out_valid}, 32'h8);
    chk("post_dat4", {24'd0, bus4.out_data[24 +: 8]}, 32'hF7);
    chk("post_vld3", {29'd0, bus3.out_valid}, 32'h4);
    chk("post_dat3", {24'd0, bus3.out_data[16 +: 8]}, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
